// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART byte receiver.
//   uart_state_e         : receiver FSM states (3-bit encoding)
//   DATA_BITS            : payload bits per frame
//   DEFAULT_CLKS_PER_BIT : 100 MHz clock at 115200 baud
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// STAGES-deep flop chain that brings an asynchronous level into the clk
// domain. Every flop resets to 1 so an idle UART line reads as idle straight
// out of reset.
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   d     in   asynchronous input
//   q     out  synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage_reg [STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg[gi] <= 1'b1;
          else        stage_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg[gi] <= 1'b1;
          else        stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule : sync_ff

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART receiver. Samples each bit at its midpoint, delivers the byte with
// a one-cycle done strobe, and flags a low stop bit with a one-cycle
// frame_err strobe. After a framing error the receiver waits for the line to
// return high, so a held-low line (break) yields a single frame_err.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   rx        in   serial line, idles high, asynchronous to clk
//   data      out  last correctly framed byte, held until the next good one
//   done      out  one-cycle pulse, data valid in the same cycle
//   frame_err out  one-cycle pulse when the stop bit samples low
//   busy      out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                 rxs;
  uart_state_e          state_reg, state_next;
  logic [CNT_W-1:0]     clk_cnt_reg;
  logic [2:0]           bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 done_reg, frame_err_reg;
  logic                 done_next, frame_err_next;
  logic                 half_hit, full_hit;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  assign half_hit = (clk_cnt_reg == HALF_LAST);
  assign full_hit = (clk_cnt_reg == FULL_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (!rxs) state_next = START;
      // A start bit that is high again at its midpoint was only a glitch.
      START:   if (half_hit) state_next = rxs ? IDLE : DATA;
      DATA:    if (full_hit && bit_idx_reg == 3'd7) state_next = STOP;
      // Leaving STOP at mid-bit lets a back-to-back start edge be seen.
      STOP:    if (full_hit) state_next = rxs ? IDLE : BREAK;
      BREAK:   if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; the pulses are registered so data and done update together.
  always_comb begin
    busy           = (state_reg != IDLE);
    done_next      = (state_reg == STOP) && full_hit && rxs;
    frame_err_next = (state_reg == STOP) && full_hit && !rxs;
  end

  // Counters, shift register and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      done_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      done_reg      <= done_next;
      frame_err_reg <= frame_err_next;
      if (done_next) data_reg <= shift_reg;

      unique case (state_reg)
        START: begin
          if (half_hit) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (full_hit) begin
            clk_cnt_reg            <= '0;
            shift_reg[bit_idx_reg] <= rxs;   // LSB arrives first
            bit_idx_reg            <= bit_idx_reg + 3'd1;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (full_hit) clk_cnt_reg <= '0;
          else          clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
        end
        default: clk_cnt_reg <= '0;  // IDLE and BREAK hold the counter cleared
      endcase
    end
  end

  assign data      = data_reg;
  assign done      = done_reg;
  assign frame_err = frame_err_reg;

endmodule : uart_byte_rx

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial 8N1 UART receiver. Turns the asynchronous `rx` line into a parallel byte plus a one-cycle `done` strobe.
- Sits directly upstream of the flag/signal generator and feeds its `data[7:0]` and `done` inputs.
- Also reports framing errors and line-break conditions so the downstream stage never sees a corrupt byte.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200). Legal range 4..65535.
- SYNC_STAGES, 2, flops in the rx metastability synchroniser. Legal range 2..3.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line; idles high; asynchronous to clk.
- data  out  8  last correctly framed byte; holds until the next good frame.
- done  out  1  one-cycle pulse; data is valid in the same cycle.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync deassert is external): data=8'h00, done=0, frame_err=0, busy=0, state=IDLE, bit counter=0, clock counter=0, synchroniser flops=1.
- rx passes through SYNC_STAGES flops; `rxs` is the synchronised value. All decisions use rxs.
- Clock counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits.
- State IDLE:
  - rxs==0 -> START; clock counter cleared.
- State START:
  - Counts to (CLKS_PER_BIT/2)-1 (integer division), then samples rxs.
  - Sample 0 -> DATA, counter cleared, bit index = 0.
  - Sample 1 -> glitch; return to IDLE with no output pulse.
- State DATA:
  - Counts CLKS_PER_BIT-1, then samples rxs into shift[bit index]. LSB first.
  - Bit index 7 sampled -> STOP; otherwise increment the bit index.
- State STOP:
  - Counts CLKS_PER_BIT-1, then samples rxs.
  - Sample 1 -> data <= shift; done=1 for exactly that one cycle; go to IDLE.
  - Sample 0 -> frame_err=1 for one cycle; data unchanged; done stays 0; go to BREAK.
- State BREAK:
  - Waits for rxs==1, then -> IDLE.
  - A low line of any length produces exactly one frame_err and no further pulses.
- Latency: done rises 2 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles (±1) after the rx falling edge, i.e. at mid-stop-bit.
- Back-to-back frames: a start bit that begins right after the stop-bit midpoint is detected. IDLE is re-entered half a bit before the stop bit ends.
- done and frame_err are never high in the same cycle. Neither is ever high for two consecutive cycles.
- Reset mid-frame: immediately return to the reset values. A partial byte is discarded and no pulse is issued. If rx is still low after reset, START is entered and treated normally (glitch or frame).
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, STOP, BREAK (3-bit encoding).
  - constants: DATA_BITS=8, DEFAULT_CLKS_PER_BIT=868.
- One sub-module, sync_ff: a parameterised SYNC_STAGES-deep synchroniser with a reset value of 1 and async active-low reset.
- No other hierarchy. A single FSM plus counters fits in about 150 lines.

Test Plan (CLKS_PER_BIT=16):
- Send 0x52, 8N1 -> exactly one done pulse; data==8'h52; frame_err never high; busy falls in the same cycle as done.
- Send 0x55 then 0x59 back-to-back with no idle gap -> two done pulses; data 8'h55 then 8'h59; 160±2 cycles between pulses.
- Drive rx low for 5 cycles, then high -> no done, no frame_err; busy returns low after the mid-start check; data unchanged.
- Send 0x53 with the stop bit forced low -> one frame_err pulse; no done; data keeps its previous value (8'h59); FSM in BREAK until rx rises.
- Hold rx low for 40 bit-times, release, then send 0x54 -> one frame_err total; then done with data==8'h54.
- Assert rst_n=0 after data bit 3 of 0x56, release, send 0x57 -> no pulse for 0x56; data==8'h00 after reset; then done with data==8'h57.
